fifo_sync_ram: RTL



---
 rtl/fifo_sync_ram.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fifo_sync_ram.sv
// First-word-fall-through FIFO around a two-port synchronous RAM (ram_two_sync).
// Defining FIFO_SYNC_RAM_LEVEL_EN builds the registered almost_full_o/almost_empty_o flags.

module ram_two_sync #(
   parameter int Width = 32,
   parameter int Depth = 256,
   localparam int Aw = $clog2(Depth)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [Aw-1:0]    waddr_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             re_i,
   input  logic [Aw-1:0]    raddr_i,
   output logic [Width-1:0] rdata_o
);

   logic [Width-1:0] mem [Depth];

   always_ff @(posedge clk_i) begin
      if (we_i) mem[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem[raddr_i];
   end

endmodule

module fifo_sync_ram #(
   parameter int Width    = 32,
   parameter int Depth    = 256,
   parameter int AfThresh = Depth - 2,
   parameter int AeThresh = 2,
   localparam int Aw = $clog2(Depth)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wvalid_i,
   output logic             wready_o,
   input  logic [Width-1:0] wdata_i,
   output logic             rvalid_o,
   input  logic             rready_i,
   output logic [Width-1:0] rdata_o,
   output logic [Aw:0]      count_o,
   output logic             almost_full_o,
   output logic             almost_empty_o
);

   localparam int Cw = Aw + 1;
   localparam logic [Aw:0] DepthLvl = Depth[Aw:0];

   if (Depth < 4 || (Depth & (Depth - 1)) != 0 || AeThresh < 0 || AfThresh > Depth)
   begin : g_bad_param
      $error("fifo_sync_ram: illegal parameter set");
   end

   // EMPTY: no head. FETCH: the RAM output register carries the head this cycle
   // (read issued last cycle). VALID: head held in head_p1.
   typedef enum logic [1:0] {EMPTY, FETCH, VALID} stage_e;

   stage_e           state_p1, state_nxt;
   logic [Aw-1:0]    wptr, rptr;
   logic [Aw:0]      count, ram_cnt;
   logic [Width-1:0] ram_dout_p1, head_p1;
   logic             push, pop, issue;

   assign wready_o = (count < DepthLvl);
   assign rvalid_o = (state_p1 != EMPTY);
   assign push     = wvalid_i && wready_o;
   assign pop      = rvalid_o && rready_i;
   assign count_o  = count;
   assign rdata_o  = (state_p1 == FETCH) ? ram_dout_p1 : head_p1;

   ram_two_sync #(
      .Width (Width),
      .Depth (Depth)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (push),
      .waddr_i (wptr),
      .wdata_i (wdata_i),
      .re_i    (issue),
      .raddr_i (rptr),
      .rdata_o (ram_dout_p1)
   );

   // ram_cnt only covers entries written in earlier cycles, so a read never
   // targets the slot being written this cycle.
   always_comb begin
      state_nxt = state_p1;
      issue     = 1'b0;
      unique case (state_p1)
         EMPTY: begin
            if (ram_cnt != '0) begin
               issue     = 1'b1;
               state_nxt = FETCH;
            end
         end
         FETCH, VALID: begin
            if (pop) begin
               if (ram_cnt != '0) begin
                  issue     = 1'b1;
                  state_nxt = FETCH;
               end else begin
                  state_nxt = EMPTY;
               end
            end else begin
               state_nxt = VALID;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // ---- control registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_p1 <= EMPTY;
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         ram_cnt  <= '0;
      end else begin
         state_p1 <= state_nxt;
         if (push)  wptr <= wptr + Aw'(1);
         if (issue) rptr <= rptr + Aw'(1);
         count   <= count + Cw'(push) - Cw'(pop);
         ram_cnt <= ram_cnt + Cw'(push) - Cw'(issue);
      end
   end

   // ---- head stage: capture the landed RAM word so it stays stable while stalled
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_p1 <= '0;
      end else if (state_p1 == FETCH) begin
         head_p1 <= ram_dout_p1;
      end
   end

`ifdef FIFO_SYNC_RAM_LEVEL_EN
   localparam logic [Aw:0] AfLvl = AfThresh[Aw:0];
   localparam logic [Aw:0] AeLvl = AeThresh[Aw:0];

   logic af_p1, ae_p1;

   // ---- level flags trail count by one cycle
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         af_p1 <= 1'b0;
         ae_p1 <= 1'b0;
      end else begin
         af_p1 <= (count >= AfLvl);
         ae_p1 <= (count <= AeLvl);
      end
   end

   assign almost_full_o  = af_p1;
   assign almost_empty_o = ae_p1;
`else
   assign almost_full_o  = 1'b0;
   assign almost_empty_o = 1'b0;
`endif

endmodule
